// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: core has priority, debug
// is protected from starvation by a wait counter and can lock the memory for itself.
module data_mem_arbiter #(
  parameter int DEPTH        = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req_valid,
  output logic        c_req_ready,
  input  logic        c_req_we,
  input  logic [3:0]  c_req_mask,
  input  logic [31:0] c_req_addr,
  input  logic [31:0] c_req_wdata,
  output logic        c_rsp_valid,
  output logic [31:0] c_rsp_rdata,
  output logic        c_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [3:0]  d_req_mask,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  input  logic        d_lock,
  output logic        mem_we,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_a,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do
);

  typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} lock_state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  lock_state_t state_reg;
  logic [7:0]  starve_cnt_reg;

  // Index 0 is the core port, index 1 the debug port.
  logic [1:0]  req_we;
  logic [1:0]  grant;
  logic [1:0]  range_err;
  logic [3:0]  req_mask  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        sel;
  logic        starved;

  assign req_we       = {d_req_we, c_req_we};
  assign req_mask[0]  = c_req_mask;
  assign req_mask[1]  = d_req_mask;
  assign req_addr[0]  = c_req_addr;
  assign req_addr[1]  = d_req_addr;
  assign req_wdata[0] = c_req_wdata;
  assign req_wdata[1] = d_req_wdata;

  assign starved = d_req_valid && (starve_cnt_reg == STARVE_MAX);

  // Grants are forced low while reset is held so nothing reaches the memory.
  always_comb begin
    grant = 2'b00;
    if (reset) begin
      if (state_reg == LOCKED) begin
        grant[1] = d_req_valid;
      end else if (starved) begin
        grant[1] = 1'b1;
      end else if (c_req_valid) begin
        grant[0] = 1'b1;
      end else begin
        grant[1] = d_req_valid;
      end
    end
  end

  assign c_req_ready = grant[0];
  assign d_req_ready = grant[1];
  assign sel         = grant[1];

  always_comb begin
    mem_we   = 1'b0;
    mem_mask = 4'h0;
    mem_a    = 32'h0;
    mem_di   = 32'h0;
    if (|grant) begin
      mem_we   = req_we[sel] && !range_err[sel];
      mem_mask = req_mask[sel];
      mem_a    = req_addr[sel];
      mem_di   = req_wdata[sel];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_port
      logic        valid_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;

      assign range_err[gi] = ({2'b00, req_addr[gi][31:2]} >= 32'(DEPTH));

      // Read data is captured at the accept edge; writes and errors return zero.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= 32'h0;
        end else begin
          valid_reg <= grant[gi];
          if (grant[gi]) begin
            err_reg   <= range_err[gi];
            rdata_reg <= (req_we[gi] || range_err[gi]) ? 32'h0 : mem_do;
          end
        end
      end
    end
  endgenerate

  assign c_rsp_valid = gen_port[0].valid_reg;
  assign c_rsp_err   = gen_port[0].err_reg;
  assign c_rsp_rdata = gen_port[0].rdata_reg;
  assign d_rsp_valid = gen_port[1].valid_reg;
  assign d_rsp_err   = gen_port[1].err_reg;
  assign d_rsp_rdata = gen_port[1].rdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= OPEN;
      starve_cnt_reg <= 8'd0;
    end else begin
      if (d_req_valid && !grant[1]) begin
        if (starve_cnt_reg != STARVE_MAX) begin
          starve_cnt_reg <= starve_cnt_reg + 8'd1;
        end
      end else begin
        starve_cnt_reg <= 8'd0;
      end
      case (state_reg)
        OPEN:    if (grant[1] && d_lock) state_reg <= LOCKED;
        LOCKED:  if (!d_lock) state_reg <= OPEN;
        default: state_reg <= OPEN;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: a behavioural memory/arbitration model
// predicts grants, memory drive and responses every cycle.
module tb_data_mem_arbiter;

  localparam int DEPTH = 64;
  localparam int SL    = 4;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [3:0]  c_req_mask;
  logic [31:0] c_req_addr, c_req_wdata;
  logic        c_rsp_valid, c_rsp_err;
  logic [31:0] c_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [3:0]  d_req_mask;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic        d_lock;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_a, mem_di, mem_do;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_mask(c_req_mask), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_mask(d_req_mask), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .d_lock(d_lock),
    .mem_we(mem_we), .mem_mask(mem_mask), .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do)
  );

  // Environment memory, written from the DUT's drive; out-of-range reads return junk.
  logic [31:0] mem_arr [DEPTH];
  logic        mem_in_range;
  assign mem_in_range = ({2'b00, mem_a[31:2]} < 32'(DEPTH));
  assign mem_do = mem_in_range ? mem_arr[mem_a[AW+1:2]] : 32'hBAD0_BAD0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          ref_locked;
  int          ref_wait;
  logic [31:0] exp_c_rdata, exp_d_rdata;
  logic        exp_c_err, exp_d_err;

  int   n_vec = 0;
  int   n_err = 0;
  int   last_win = 0;
  logic obs_c, obs_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return ({2'b00, a[31:2]} < 32'(DEPTH));
  endfunction

  // 0 = no grant, 1 = core, 2 = debug
  function automatic int pick_winner();
    if (!reset) return 0;
    if (ref_locked) return d_req_valid ? 2 : 0;
    if (d_req_valid && ref_wait >= SL) return 2;
    if (c_req_valid) return 1;
    if (d_req_valid) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0)
      return (32'($urandom_range(DEPTH, DEPTH + 300)) << 2) | 32'($urandom_range(0, 3));
    return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    ref_locked  = 1'b0;
    ref_wait    = 0;
    exp_c_rdata = 32'h0; exp_d_rdata = 32'h0;
    exp_c_err   = 1'b0;  exp_d_err   = 1'b0;
  endtask

  // One clock cycle: inputs were set during the low phase; returns at the next negedge.
  task automatic step(input bit verbose);
    int          w;
    logic        we_x;
    logic [3:0]  mk_x;
    logic [31:0] a_x, di_x, rd_x;
    bit          err_x, dv_x, dl_x;
    logic        e_we;
    logic [3:0]  e_mk;
    logic [31:0] e_a, e_di;
    #1;
    w = pick_winner();
    we_x = 1'b0; mk_x = 4'h0; a_x = 32'h0; di_x = 32'h0;
    if (w == 1) begin
      we_x = c_req_we; mk_x = c_req_mask; a_x = c_req_addr; di_x = c_req_wdata;
    end else if (w == 2) begin
      we_x = d_req_we; mk_x = d_req_mask; a_x = d_req_addr; di_x = d_req_wdata;
    end
    err_x = (w != 0) && !addr_ok(a_x);
    dv_x  = d_req_valid;
    dl_x  = d_lock;
    obs_c = c_req_ready;
    obs_d = d_req_ready;
    check("c_ready", 32'(c_req_ready), 32'(w == 1));
    check("d_ready", 32'(d_req_ready), 32'(w == 2));
    check("mem_we", 32'(mem_we), 32'((w != 0) && we_x && !err_x));
    check("mem_mask", 32'(mem_mask), 32'(mk_x));
    check("mem_a", mem_a, a_x);
    check("mem_di", mem_di, di_x);
    rd_x = (w == 0 || we_x || err_x) ? 32'h0 : ref_mem[a_x[AW+1:2]];
    e_we = mem_we; e_mk = mem_mask; e_a = mem_a; e_di = mem_di;
    @(posedge clk);
    #1;
    if (e_we && addr_ok(e_a))
      for (int b = 0; b < 4; b++)
        if (e_mk[b]) mem_arr[e_a[AW+1:2]][8*b +: 8] = e_di[8*b +: 8];
    if (w != 0 && we_x && !err_x)
      for (int b = 0; b < 4; b++)
        if (mk_x[b]) ref_mem[a_x[AW+1:2]][8*b +: 8] = di_x[8*b +: 8];
    if (w == 1) begin exp_c_rdata = rd_x; exp_c_err = err_x; end
    if (w == 2) begin exp_d_rdata = rd_x; exp_d_err = err_x; end
    if (dv_x && w != 2) ref_wait = (ref_wait < SL) ? ref_wait + 1 : SL;
    else ref_wait = 0;
    if (ref_locked) begin
      if (!dl_x) ref_locked = 1'b0;
    end else if (w == 2 && dl_x) begin
      ref_locked = 1'b1;
    end
    check("c_rsp_valid", 32'(c_rsp_valid), 32'(w == 1));
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(w == 2));
    check("c_rsp_rdata", c_rsp_rdata, exp_c_rdata);
    check("d_rsp_rdata", d_rsp_rdata, exp_d_rdata);
    check("c_rsp_err", 32'(c_rsp_err), 32'(exp_c_err));
    check("d_rsp_err", 32'(d_rsp_err), 32'(exp_d_err));
    if (verbose && w != 0)
      $display("txn %s we=%0b addr=%08h wdata=%08h mask=%h -> rdata=%08h err=%0b",
               (w == 1) ? "core " : "debug", we_x, a_x, di_x, mk_x, rd_x, err_x);
    last_win = w;
    @(negedge clk);
  endtask

  task automatic set_c(input logic v, input logic we, input logic [3:0] mk,
                       input logic [31:0] a, input logic [31:0] di);
    c_req_valid = v; c_req_we = we; c_req_mask = mk; c_req_addr = a; c_req_wdata = di;
  endtask

  task automatic set_d(input logic v, input logic we, input logic [3:0] mk,
                       input logic [31:0] a, input logic [31:0] di);
    d_req_valid = v; d_req_we = we; d_req_mask = mk; d_req_addr = a; d_req_wdata = di;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_c_ready"}, 32'(c_req_ready), 32'h0);
    check({tag, "_d_ready"}, 32'(d_req_ready), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_mem_mask"}, 32'(mem_mask), 32'h0);
    check({tag, "_mem_a"}, mem_a, 32'h0);
    check({tag, "_mem_di"}, mem_di, 32'h0);
    check({tag, "_c_rsp_v"}, 32'(c_rsp_valid), 32'h0);
    check({tag, "_d_rsp_v"}, 32'(d_rsp_valid), 32'h0);
    check({tag, "_c_rdata"}, c_rsp_rdata, 32'h0);
    check({tag, "_d_rdata"}, d_rsp_rdata, 32'h0);
    check({tag, "_c_err"}, 32'(c_rsp_err), 32'h0);
    check({tag, "_d_err"}, 32'(d_rsp_err), 32'h0);
  endtask

  initial begin
    logic [31:0] v, old_word;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    model_reset();
    reset = 1'b1;
    d_lock = 1'b0;
    set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #2;
    reset = 1'b0;
    set_c(1'b1, 1'b1, 4'hF, 32'h4, 32'h12345678);
    set_d(1'b1, 1'b1, 4'hF, 32'h8, 32'h87654321);
    #1;
    check_all_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;

    // Core write then read-back
    set_c(1'b1, 1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    step(1);
    set_c(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    step(1);
    check("t1_valid", 32'(c_rsp_valid), 32'h1);
    check("t1_rdata", c_rsp_rdata, 32'hDEADBEEF);
    check("t1_err", 32'(c_rsp_err), 32'h0);

    // Both ports request every cycle: debug wins once the wait count saturates
    set_c(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_d(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("starve_seq", {30'h0, obs_d, obs_c}, (i == 4) ? 32'h2 : 32'h1);
      if (obs_d) d_req_valid = 1'b0;
    end
    set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Debug partial-lane write merged into a core-written word
    set_c(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
    step(1);
    set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b1, 1'b1, 4'h2, 32'h20, 32'h0000AB00);
    step(1);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_c(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    step(1);
    check("mask_merge", c_rsp_rdata, 32'h1122AB44);

    // Out-of-range read and write
    set_c(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step(1);
    check("oor_err", 32'(c_rsp_err), 32'h1);
    check("oor_rdata", c_rsp_rdata, 32'h0);
    set_c(1'b1, 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF);
    step(1);
    check("oor_werr", 32'(c_rsp_err), 32'h1);
    set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Lock: debug takes the memory, core is blocked until d_lock drops
    d_lock = 1'b1;
    set_d(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    step(1);
    check("lock_dgrant", 32'(obs_d), 32'h1);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_c(1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("lock_cblk", 32'(obs_c), 32'h0);
    end
    d_lock = 1'b0;
    step(1);
    check("unlock_edge", 32'(obs_c), 32'h0);
    step(1);
    check("unlock_cgo", 32'(obs_c), 32'h1);
    set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset asserted in the middle of a granted write while locked
    d_lock = 1'b1;
    set_d(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    step(1);
    old_word = ref_mem[12];
    set_d(1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
    set_c(1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    #2;
    check("rst_pre_we", 32'(mem_we), 32'h1);
    reset = 1'b0;
    #1;
    check_all_idle("rst_mid");
    @(posedge clk);
    #1;
    check_all_idle("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1);
    check("rst_open", 32'(obs_c), 32'h1);
    check("rst_nowrite", c_rsp_rdata, old_word);
    d_lock = 1'b0;
    set_c(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1);

    // Randomized traffic respecting the hold-while-stalled rule
    $display("random phase: 1500 cycles");
    for (int i = 0; i < 1500; i++) begin
      if (!c_req_valid || last_win == 1)
        set_c(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      if (!d_req_valid || last_win == 2)
        set_d(1'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      if ($urandom_range(0, 11) == 0) d_lock = ~d_lock;
      step(0);
    end

    for (int i = 0; i < DEPTH; i++) check("final_mem", mem_arr[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory between two requesters: the core load/store port (port c, high priority) and the debug/DMA port (port d). It picks one access per cycle and drives the memory's combinational-read, synchronous-write interface. It also returns a registered response to the winner, prevents debug starvation with a wait counter, and supports a debug lock for exclusive multi-cycle access. Placement: between the core/debug units and the data memory.

## Interface

Parameters:
- DEPTH, 64: memory size in 32-bit words; word index = addr[31:2].
- STARVE_LIMIT, 4: consecutive lost cycles after which a waiting debug request beats the core; range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req_valid / d_req_valid  in  1  request present.
- c_req_ready / d_req_ready  out  1  request accepted this cycle (combinational grant).
- c_req_we / d_req_we  in  1  1 = write, 0 = read.
- c_req_mask / d_req_mask  in  4  byte-lane write enables; bit i covers bits [8i+7:8i].
- c_req_addr / d_req_addr  in  32  byte address.
- c_req_wdata / d_req_wdata  in  32  write data.
- c_rsp_valid / d_rsp_valid  out  1  one-cycle response pulse.
- c_rsp_rdata / d_rsp_rdata  out  32  read data; 0 for writes and errors.
- c_rsp_err / d_rsp_err  out  1  out-of-range address.
- d_lock  in  1  debug requests exclusive access.
- mem_we  out  1  memory write enable.
- mem_mask  out  4  memory byte mask.
- mem_a  out  32  memory byte address.
- mem_di  out  32  memory write data.
- mem_do  in  32  memory combinational read data.

## Operation

- Handshake: a request transfers when valid && ready. The requester holds all req_* stable while valid && !ready. Responses have no backpressure.
- Grant selection, evaluated each cycle, at most one grant:
  - In LOCKED: debug only. c_req_ready = 0.
  - In OPEN: debug wins if d_req_valid && starve_cnt == STARVE_LIMIT.
  - Otherwise core wins if c_req_valid, else debug wins if d_req_valid.
- Memory drive:
  - With a grant: mem_a, mem_mask and mem_di come from the winner. mem_we = winner.we && !range_err.
  - With no grant: mem_we = 0, mem_mask = 0, mem_a = 0, mem_di = 0.
- range_err = (addr[31:2] >= DEPTH). An erroring access is still accepted, never writes, and responds with err = 1 and rdata = 0.
- Write with mask == 0: accepted, mem_we = 1, no bytes change, normal ack.
- starve_cnt (8 bit):
  - Increments, saturating at STARVE_LIMIT, when d_req_valid && !d_req_ready.
  - Clears when debug is granted or d_req_valid = 0.
- Lock FSM, states OPEN and LOCKED:
  - OPEN -> LOCKED on a debug handshake with d_lock = 1.
  - LOCKED -> OPEN on any edge where d_lock = 0, with or without a debug request.
  - d_lock = 1 with no debug handshake does not lock.
- Reset (reset = 0, asynchronous):
  - FSM = OPEN, starve_cnt = 0.
  - All rsp_valid, rsp_err = 0; all rsp_rdata = 0.
  - Both req_ready = 0 while reset is asserted.
  - An access granted in the cycle reset asserts produces no response.

## Timing

- Accept cycle N: memory signals are driven combinationally in N and a write commits at the end-of-N edge. mem_do is captured into the winner's rsp_rdata at that edge.
- Response: the winner's rsp_valid = 1 in cycle N+1 only, with rdata/err held until the next response to that port.
- Throughput: one access per cycle. Back-to-back grants to the same port give rsp_valid high on consecutive cycles.
- Read-after-write from either port in consecutive cycles returns the new data, because the memory read is combinational.
- Lock transitions take effect in the cycle after the deciding edge. Core grants resume in the first cycle after d_lock = 0 is sampled.
- Starvation: with the core requesting continuously, a debug request is granted no later than cycle STARVE_LIMIT+1 after it is first presented.

## Test plan

- Reset, then core write addr 0x8 wdata 0xDEADBEEF mask 0xF, then core read 0x8 -> rsp_valid next cycle each; read rdata 0xDEADBEEF, err 0.
- Both ports request every cycle, STARVE_LIMIT = 4 -> core granted 4 cycles, debug granted on the 5th, then core resumes and starve_cnt = 0.
- Debug write mask 0x2 wdata 0x0000AB00 to a word holding 0x11223344, then core read -> 0x1122AB44.
- Core read addr 0x100 with DEPTH = 64 -> rsp_err = 1, rdata 0, mem_we never 1; a write to 0x100 changes no word.
- Debug read with d_lock = 1 while the core requests for 6 cycles -> c_req_ready stays 0; drop d_lock -> core granted the following cycle.
- Assert reset mid-stream during a granted write -> all outputs 0 immediately, no rsp_valid after release, FSM OPEN.
